// File: rtl/mem_access_unit.sv
// MIPS memory stage: formats loads/stores onto a req/ack bus, stalls upstream while a
// transaction is outstanding, and registers the writeback entry.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_ALUres,
    input  logic [31:0] i_op2,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [4:0]  i_rd,
    input  logic        i_regWrite,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd,
    output logic        o_regWrite,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    // Access attributes captured at issue so completion does not depend on upstream holding
    logic [1:0] off_q;
    logic [1:0] size_q;
    logic       signed_q;
    logic       load_q;
    logic [4:0] rd_q;
    logic       rw_q;

    logic        is_mem;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        is_mem = i_memRead | i_memWrite;
        case (i_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = i_ALUres[0];
            default: misaligned = (i_ALUres[1:0] != 2'b00);
        endcase

        timeout = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));

        o_stall = ((state == IDLE) && i_valid && is_mem && !misaligned) ||
                  ((state == WAIT) && !i_bus_ack && !timeout);

        case (i_size)
            2'b00: begin
                be_next    = 4'b0001 << i_ALUres[1:0];
                wdata_next = {4{i_op2[7:0]}};
            end
            2'b01: begin
                be_next    = i_ALUres[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{i_op2[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = i_op2;
            end
        endcase

        shifted = i_bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_val = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'h0, shifted[7:0]};
            2'b01:   load_val = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            to_cnt       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            load_q       <= 1'b0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wdata  <= '0;
            o_bus_be     <= '0;
            o_valid      <= 1'b0;
            o_result     <= '0;
            o_rd         <= '0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (!is_mem) begin
                            o_valid    <= 1'b1;
                            o_result   <= i_ALUres;
                            o_rd       <= i_rd;
                            o_regWrite <= i_regWrite;
                        end else if (misaligned) begin
                            o_valid      <= 1'b1;
                            o_rd         <= i_rd;
                            o_misaligned <= 1'b1;
                        end else begin
                            state       <= WAIT;
                            to_cnt      <= '0;
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= i_memWrite;
                            o_bus_addr  <= {i_ALUres[31:2], 2'b00};
                            o_bus_be    <= be_next;
                            o_bus_wdata <= wdata_next;
                            off_q       <= i_ALUres[1:0];
                            size_q      <= i_size;
                            signed_q    <= i_signed;
                            load_q      <= i_memRead;
                            rd_q        <= i_rd;
                            rw_q        <= i_regWrite;
                        end
                    end
                end
                WAIT: begin
                    // Ack takes priority over a timeout landing in the same cycle
                    if (i_bus_ack) begin
                        state      <= IDLE;
                        o_bus_req  <= 1'b0;
                        o_valid    <= 1'b1;
                        o_rd       <= rd_q;
                        o_regWrite <= rw_q & load_q;
                        if (load_q) begin
                            o_result <= load_val;
                        end
                    end else if (timeout) begin
                        state     <= IDLE;
                        o_bus_req <= 1'b0;
                        o_valid   <= 1'b1;
                        o_bus_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: driver pushes expected writeback
// entries, an independent monitor pops and compares them whenever o_valid is seen.
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_ALUres = '0;
    logic [31:0] i_op2 = '0;
    logic        i_memRead = 1'b0;
    logic        i_memWrite = 1'b0;
    logic [1:0]  i_size = '0;
    logic        i_signed = 1'b0;
    logic [4:0]  i_rd = '0;
    logic        i_regWrite = 1'b0;
    logic        o_stall;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_regWrite;
    logic        o_misaligned;
    logic        o_bus_err;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_ALUres(i_ALUres),
        .i_op2(i_op2), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
        .i_size(i_size), .i_signed(i_signed), .i_rd(i_rd), .i_regWrite(i_regWrite),
        .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_valid(o_valid),
        .o_result(o_result), .o_rd(o_rd), .o_regWrite(o_regWrite),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        bit          chk_res;
        logic [4:0]  rd;
        bit          chk_rd;
        logic        rw;
        logic        mis;
        logic        err;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Reference model: lane-level view of the access
    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be = '0;
        for (int unsigned i = 0; i < 4; i++)
            be[i] = (i >= off) && (i < off + nbytes(sz));
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] op2);
        logic [31:0] w;
        for (int unsigned i = 0; i < 4; i++)
            w[8*i +: 8] = op2[8*(i % nbytes(sz)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic [1:0] off, input logic sg);
        logic [31:0]  v = '0;
        int unsigned  n = nbytes(sz);
        for (int unsigned j = 0; j < n; j++)
            v[8*j +: 8] = rd[8*(off + j) +: 8];
        if (sg && v[8*n - 1])
            for (int unsigned j = n; j < 4; j++)
                v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    // Monitor: decoupled from stimulus, compares every presented writeback entry
    always @(negedge i_clk) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: got o_valid=1 expected no entry (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_due_cycle", 32'(cyc), 32'(e.due));
                if (e.chk_res) chk("wb_result", o_result, e.res);
                if (e.chk_rd)  chk("wb_rd", 32'(o_rd), 32'(e.rd));
                chk("wb_regWrite", 32'(o_regWrite), 32'(e.rw));
                chk("wb_misaligned", 32'(o_misaligned), 32'(e.mis));
                chk("wb_bus_err", 32'(o_bus_err), 32'(e.err));
            end
        end else if (o_misaligned === 1'b1 || o_bus_err === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL flag_without_valid: got mis=%b err=%b expected 0 (cycle %0d)",
                     o_misaligned, o_bus_err, cyc);
        end
    end

    task automatic run_op(input logic mr, input logic mw, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] op2, input logic [4:0] rd,
                          input logic rw, input int dly, input logic [31:0] rdata);
        exp_t       e;
        int         stalls;
        int         exp_stalls;
        bit         done;
        logic [1:0] off;
        logic       mem;
        logic       mis;
        i_valid = 1'b1; i_memRead = mr; i_memWrite = mw; i_size = sz; i_signed = sg;
        i_ALUres = a; i_op2 = op2; i_rd = rd; i_regWrite = rw;
        off = a[1:0];
        mem = mr | mw;
        mis = mem && ((sz == 2'b01 && off[0]) || (sz[1] && off != 2'b00));
        @(negedge i_clk);
        chk("req_idle", 32'(o_bus_req), 32'd0);
        if (!mem || mis) begin
            chk("stall_nobus", 32'(o_stall), 32'd0);
            e.res = a; e.chk_res = !mem; e.rd = rd; e.chk_rd = !mis;
            e.rw = mem ? 1'b0 : rw; e.mis = mis; e.err = 1'b0; e.due = cyc + 1;
            exp_q.push_back(e);
            tick;
            i_valid = 1'b0;
            return;
        end
        stalls = (o_stall === 1'b1) ? 1 : 0;
        tick;
        done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (k == dly) begin
                i_bus_ack = 1'b1;
                i_bus_rdata = rdata;
            end
            @(negedge i_clk);
            chk("bus_req", 32'(o_bus_req), 32'd1);
            chk("bus_we", 32'(o_bus_we), 32'(mw));
            chk("bus_addr", o_bus_addr, {a[31:2], 2'b00});
            chk("bus_be", 32'(o_bus_be), 32'(ref_be(sz, off)));
            if (mw) chk("bus_wdata", o_bus_wdata, ref_wdata(sz, op2));
            if (o_stall === 1'b1) stalls++;
            if (k == dly) begin
                e.res = ref_load(rdata, sz, off, sg); e.chk_res = mr;
                e.rd = rd; e.chk_rd = 1; e.rw = rw & mr; e.mis = 0; e.err = 0;
                done = 1;
            end else if (TIMEOUT != 0 && k == int'(TIMEOUT) - 1) begin
                e.res = '0; e.chk_res = 0; e.rd = rd; e.chk_rd = 0;
                e.rw = 0; e.mis = 0; e.err = 1;
                done = 1;
            end
            if (done) begin
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
            tick;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL op_bound: got no completion expected completion within 64 cycles");
        end
        i_bus_ack = 1'b0;
        i_valid = 1'b0;
        exp_stalls = (TIMEOUT == 0 || dly < int'(TIMEOUT)) ? dly + 1 : int'(TIMEOUT);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    endtask

    task automatic bubble(input logic stray_ack);
        i_valid = 1'b0;
        i_memRead = 1'($urandom_range(0, 1));
        i_bus_ack = stray_ack;
        @(negedge i_clk);
        chk("bubble_stall", 32'(o_stall), 32'd0);
        chk("bubble_req", 32'(o_bus_req), 32'd0);
        tick;
        i_bus_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_req", 32'(o_bus_req), 32'd0);
        chk("rst_regWrite", 32'(o_regWrite), 32'd0);
        chk("rst_misaligned", 32'(o_misaligned), 32'd0);
        chk("rst_bus_err", 32'(o_bus_err), 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_addr", o_bus_addr, 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        tick;

        run_op(0, 0, 2'b10, 0, 32'h0000_0042, 32'h0, 5'd5, 1, 0, 32'h0);
        run_op(1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 5'd7, 1, 3, 32'h80AA_BBCC);
        run_op(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 5'd8, 1, 3, 32'h80AA_BBCC);
        run_op(0, 1, 2'b01, 0, 32'h0000_2002, 32'h1234_5678, 5'd9, 1, 0, 32'h0);
        run_op(1, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 5'd10, 1, 0, 32'h0);
        run_op(1, 0, 2'b10, 0, 32'h0000_3004, 32'h0, 5'd11, 1, 99, 32'h0);
        run_op(1, 0, 2'b10, 0, 32'h0000_3008, 32'h0, 5'd12, 1, 15, 32'hDEAD_BEEF);
        bubble(1'b1);

        for (int n = 0; n < 80; n++) begin
            logic mr, mw;
            int   dly;
            case ($urandom_range(0, 2))
                0:       begin mr = 0; mw = 0; end
                1:       begin mr = 1; mw = 0; end
                default: begin mr = 0; mw = 1; end
            endcase
            dly = ($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(0, 5));
            run_op(mr, mw, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                   $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), dly, $urandom);
            if ($urandom_range(0, 3) == 0) bubble(1'($urandom_range(0, 1)));
        end

        // Reset while a load is outstanding, then a late ack
        i_valid = 1'b1; i_memRead = 1'b1; i_memWrite = 1'b0; i_size = 2'b10;
        i_ALUres = 32'h0000_4000; i_rd = 5'd3; i_regWrite = 1'b1;
        tick;
        tick;
        i_rst = 1'b1;
        i_valid = 1'b0;
        tick;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rstwait_req", 32'(o_bus_req), 32'd0);
        chk("rstwait_valid", 32'(o_valid), 32'd0);
        chk("rstwait_stall", 32'(o_stall), 32'd0);
        i_bus_ack = 1'b1;
        i_bus_rdata = 32'h1111_2222;
        tick;
        i_bus_ack = 1'b0;
        @(negedge i_clk);
        chk("lateack_req", 32'(o_bus_req), 32'd0);
        chk("lateack_valid", 32'(o_valid), 32'd0);
        tick;

        bubble(1'b0);
        bubble(1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the MIPS pipeline. Consumes the execute stage's ALU result (the effective address) and second operand (the store data), and performs loads and stores on a req/ack data bus.
- Formats load data (byte/half/word, sign or zero extension) and registers the result toward writeback.
- Stalls the upstream pipeline while a bus transaction is outstanding.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- TIMEOUT, 16: max cycles to wait for i_bus_ack before aborting; 0 disables the timeout.
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  instruction present from execute
- i_ALUres  input  32  effective address, or ALU result for non-memory ops
- i_op2  input  32  store data
- i_memRead  input  1  load
- i_memWrite  input  1  store (memRead and memWrite never both set)
- i_size  input  2  00 byte, 01 half, 10 word (11 treated as word)
- i_signed  input  1  sign-extend loads (1) or zero-extend (0)
- i_rd  input  5  destination register
- i_regWrite  input  1  instruction writes rd
- o_stall  output  1  hold execute inputs stable this cycle
- o_bus_req  output  1  bus request
- o_bus_we  output  1  1 = write
- o_bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- o_bus_wdata  output  32  lane-replicated store data
- o_bus_be  output  4  byte enables, little-endian
- i_bus_ack  input  1  transaction complete, single-cycle pulse
- i_bus_rdata  input  32  read data, valid with ack
- o_valid  output  1  writeback entry valid
- o_result  output  32  writeback value
- o_rd  output  5  writeback register
- o_regWrite  output  1  writeback enable
- o_misaligned  output  1  1-cycle pulse: misaligned access dropped
- o_bus_err  output  1  1-cycle pulse: timeout abort

Behaviour:
- Reset: state IDLE; every output register cleared (o_bus_req, o_valid, o_regWrite, o_misaligned, o_bus_err = 0; data outputs = 0); timeout counter = 0.
- Reset mid-WAIT: o_bus_req is 0 from the next cycle; no o_valid is produced for the aborted op.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠00.
- o_stall (combinational):
  - (IDLE & i_valid & (memRead|memWrite) & aligned), or
  - (WAIT & !i_bus_ack & !timeout).
  - Upstream advances only at an edge where o_stall=0.
- IDLE, i_valid, non-memory op: next edge o_valid=1, o_result=i_ALUres, o_rd/o_regWrite copied. Latency 1, no stall.
- IDLE, i_valid, misaligned memory op: no bus access. Next edge o_valid=1, o_regWrite=0, o_misaligned=1. No stall.
- IDLE, i_valid, aligned memory op: stall this cycle; next edge enter WAIT.
  - Register o_bus_req=1, we=memWrite, addr, be, wdata; clear the counter.
  - o_valid=0 for that cycle.
- Byte enables:
  - byte: 1<<addr[1:0], wdata={4{op2[7:0]}}
  - half: addr[1] ? 1100 : 0011, wdata={2{op2[15:0]}}
  - word: 1111, wdata=op2
- Bus outputs are stable throughout WAIT.
- WAIT, ack: stall=0 this cycle (inputs still hold the same op). Next edge:
  - req=0; state IDLE.
  - o_valid=1, o_rd copied.
  - o_regWrite = i_regWrite & memRead; stores give o_regWrite=0.
- Load result: i_bus_rdata >> (8*addr[1:0]); low 8/16/32 bits, extended per i_signed.
- WAIT, no ack: counter increments each cycle.
- Timeout (TIMEOUT≠0, counter == TIMEOUT-1 with no ack): stall=0 this cycle. Next edge:
  - req=0; state IDLE.
  - o_valid=1, o_regWrite=0, o_bus_err=1.
- Ack arriving in the same cycle as timeout: ack wins; normal completion.
- i_bus_ack outside WAIT is ignored.
- o_valid deasserts after one cycle unless a new op completes.

Test Plan:
- Reset, then non-memory op (ALUres=0x0000_0042, rd=5, regWrite=1) -> next cycle o_valid=1, o_result=0x42, o_rd=5, o_regWrite=1; o_stall=0 throughout.
- Signed byte load at addr 0x1003, ack after 3 cycles with rdata=0x80AA_BBCC:
  - o_bus_be=1000, o_bus_addr=0x1000, o_stall=1 for 4 cycles;
  - o_result=0xFFFF_FF80.
  - Repeat unsigned -> 0x0000_0080.
- Half store at 0x2002, op2=0x1234_5678, ack next cycle -> o_bus_we=1, be=1100, wdata=0x5678_5678; completion o_valid=1, o_regWrite=0.
- Word load at 0x3001 -> no o_bus_req; next cycle o_misaligned=1, o_valid=1, o_regWrite=0.
- Word load, no ack, TIMEOUT=16 -> o_stall high 16 cycles, then o_bus_err=1, o_bus_req=0. Ack on cycle 16 instead -> normal load result, o_bus_err=0.
- Assert i_rst during WAIT -> next cycle o_bus_req=0, o_valid=0, o_stall=0. A late ack is ignored.
